// File: rtl/nco_wave.sv
// nco_wave: phase-accumulator NCO emitting offset-binary sine/square/sawtooth/triangle samples
// Ports: clk, rst (sync, active-high); en takes a sample; sync clears the accumulator;
// freq_word is the phase step; phase_off is added to the table address; mode selects the waveform;
// out/out_valid/out_wrap form the registered sample stream, two edges after the en edge.
module nco_wave #(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [LUT_AW-1:0]  phase_off,
  input  logic [1:0]         mode,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               out_wrap
);
  localparam int N = 2 ** (LUT_AW - 2);
  localparam int A = 2 ** (OUT_W - 1) - 1;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [LUT_AW-2:0] N_V = {1'b1, {(LUT_AW-2){1'b0}}};
  // Quarter-wave sample round(A*sin(pi/2*k/N)) via a Q30 Taylor series, so the table
  // needs no real-number math at elaboration.
  function automatic int sin_rom(input int k);
    longint x, x2, t, s;
    x = (longint'(k) * 64'sd1686629713) / longint'(N);
    x2 = (x * x) >>> 30;
    t = x;
    s = x;
    for (int n = 1; n <= 8; n++) begin
      t = -(((t * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      s = s + t;
    end
    return int'((longint'(A) * s + (64'sd1 <<< 29)) >>> 30);
  endfunction
  logic [OUT_W-2:0]   w_rom [0:N];
  for (genvar g = 0; g <= N; g++) begin : g_rom
    localparam int V = sin_rom(g);
    assign w_rom[g] = V[OUT_W-2:0];
  end
  logic [PHASE_W-1:0] r_acc;
  logic [LUT_AW-1:0]  r_a1;
  logic [1:0]         r_mode1;
  logic               r_v1, r_w1;
  logic [PHASE_W:0]   w_sum;
  logic [LUT_AW-1:0]  w_addr, w_tri_sh, w_r;
  logic [LUT_AW-2:0]  w_i, w_idx;
  logic [1:0]         w_q;
  logic [OUT_W-2:0]   w_mag;
  logic [OUT_W-1:0]   w_sine, w_sq, w_rs, w_wave;
  assign w_sum  = {1'b0, r_acc} + {1'b0, freq_word};
  assign w_addr = r_acc[PHASE_W-1 -: LUT_AW] + phase_off;
  assign w_q    = r_a1[LUT_AW-1 -: 2];
  assign w_i    = {1'b0, r_a1[LUT_AW-3:0]};
  // Odd quadrants read the quarter table mirrored; index N is the peak entry.
  assign w_idx  = w_q[0] ? N_V - w_i : w_i;
  assign w_mag  = w_rom[w_idx];
  assign w_sine = w_q[1] ? MID - {1'b0, w_mag} : MID + {1'b0, w_mag};
  assign w_sq   = r_a1[LUT_AW-1] ? OUT_W'(1) : {OUT_W{1'b1}};
  assign w_tri_sh = {r_a1[LUT_AW-2:0], 1'b0};
  assign w_r    = (r_mode1 == 2'd2) ? r_a1 : (r_a1[LUT_AW-1] ? ~w_tri_sh : w_tri_sh);
  if (OUT_W <= LUT_AW) begin : g_trunc
    assign w_rs = w_r[LUT_AW-1 -: OUT_W];
  end else begin : g_widen
    assign w_rs = {w_r, {(OUT_W-LUT_AW){1'b0}}};
  end
  assign w_wave = (r_mode1 == 2'd0) ? w_sine : (r_mode1 == 2'd1) ? w_sq : w_rs;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_a1      <= '0;
      r_mode1   <= '0;
      r_v1      <= 1'b0;
      r_w1      <= 1'b0;
      out       <= MID;
      out_valid <= 1'b0;
      out_wrap  <= 1'b0;
    end else begin
      r_v1 <= en && !sync;
      if (sync) begin
        r_acc <= '0;
      end else if (en) begin
        r_acc   <= w_sum[PHASE_W-1:0];
        r_a1    <= w_addr;
        r_mode1 <= mode;
        r_w1    <= w_sum[PHASE_W];
      end
      out_valid <= r_v1;
      out_wrap  <= r_v1 && r_w1;
      if (r_v1) out <= w_wave;
    end
  end
endmodule
